// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift/update stages with one-hot decode.
// Any opcode other than EXTEST, SAMPLE or IDCODE decodes to BYPASS.
module jtag_ir_param #(
    parameter int                    IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]   OP_EXTEST = IR_WIDTH'(4'b0000),
    parameter logic [IR_WIDTH-1:0]   OP_SAMPLE = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0]   OP_IDCODE = IR_WIDTH'(4'b0010)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  captureir,
    input  logic                  shiftir,
    input  logic                  updateir,
    input  logic                  tdi,
    input  logic [IR_WIDTH-3:0]   capture_status,
    output logic                  tdo,
    output logic [IR_WIDTH-1:0]   instr,
    output logic                  sel_extest,
    output logic                  sel_sample,
    output logic                  sel_idcode,
    output logic                  sel_bypass
);

    logic [IR_WIDTH-1:0] sr;
    logic [IR_WIDTH-1:0] ir;

    // update always samples the pre-edge sr, so shift+update on one edge is well defined
    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
            ir <= OP_IDCODE;
        end else begin
            if (captureir)
                sr <= {capture_status, 2'b01};
            else if (shiftir)
                sr <= {tdi, sr[IR_WIDTH-1:1]};
            if (updateir)
                ir <= sr;
        end
    end

    assign tdo   = sr[0];
    assign instr = ir;

    always_comb begin
        sel_extest = 1'b0;
        sel_sample = 1'b0;
        sel_idcode = 1'b0;
        sel_bypass = 1'b0;
        if (ir == OP_EXTEST)
            sel_extest = 1'b1;
        else if (ir == OP_SAMPLE)
            sel_sample = 1'b1;
        else if (ir == OP_IDCODE)
            sel_idcode = 1'b1;
        else
            sel_bypass = 1'b1;
    end

endmodule

// File: tb/tb_jtag_ir_param.sv
// Scoreboard bench for jtag_ir_param: 4-bit default instance and an 8-bit instance.
module tb_jtag_ir_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 4-bit instance
    logic       reset_a, cap_a, sh_a, up_a, tdi_a;
    logic [1:0] st_a;
    logic       tdo_a;
    logic [3:0] instr_a;
    logic       ext_a, smp_a, idc_a, byp_a;

    jtag_ir_param dut_a (
        .clock(clock), .reset(reset_a), .captureir(cap_a), .shiftir(sh_a),
        .updateir(up_a), .tdi(tdi_a), .capture_status(st_a), .tdo(tdo_a),
        .instr(instr_a), .sel_extest(ext_a), .sel_sample(smp_a),
        .sel_idcode(idc_a), .sel_bypass(byp_a)
    );

    // 8-bit instance
    logic       reset_b, cap_b, sh_b, up_b, tdi_b;
    logic [5:0] st_b;
    logic       tdo_b;
    logic [7:0] instr_b;
    logic       ext_b, smp_b, idc_b, byp_b;

    jtag_ir_param #(
        .IR_WIDTH(8), .OP_EXTEST(8'h00), .OP_SAMPLE(8'h01), .OP_IDCODE(8'h02)
    ) dut_b (
        .clock(clock), .reset(reset_b), .captureir(cap_b), .shiftir(sh_b),
        .updateir(up_b), .tdi(tdi_b), .capture_status(st_b), .tdo(tdo_b),
        .instr(instr_b), .sel_extest(ext_b), .sel_sample(smp_b),
        .sel_idcode(idc_b), .sel_bypass(byp_b)
    );

    typedef struct {
        string      name;
        bit         w8;
        int         due;
        logic       tdo;
        logic [7:0] instr;
        logic [7:0] sr;
        logic [3:0] sel;   // {extest, sample, idcode, bypass}
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // monitor: compare every entry whose edge has passed
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic       a_tdo;
            logic [7:0] a_instr, a_sr;
            logic [3:0] a_sel;
            e = q.pop_front();
            if (e.w8) begin
                a_tdo = tdo_b; a_instr = instr_b; a_sr = dut_b.sr;
                a_sel = {ext_b, smp_b, idc_b, byp_b};
            end else begin
                a_tdo = tdo_a; a_instr = {4'h0, instr_a}; a_sr = {4'h0, dut_a.sr};
                a_sel = {ext_a, smp_a, idc_a, byp_a};
            end
            tests++;
            if (a_tdo !== e.tdo) begin
                failed++;
                $display("FAIL %s tdo: got %b want %b", e.name, a_tdo, e.tdo);
            end
            tests++;
            if (a_instr !== e.instr) begin
                failed++;
                $display("FAIL %s instr: got %h want %h", e.name, a_instr, e.instr);
            end
            tests++;
            if (a_sel !== e.sel) begin
                failed++;
                $display("FAIL %s sel: got %b want %b", e.name, a_sel, e.sel);
            end
            tests++;
            if (a_sr !== e.sr) begin
                failed++;
                $display("FAIL %s sr: got %h want %h", e.name, a_sr, e.sr);
            end
        end
    end

    localparam logic [3:0] S_EXT = 4'b1000, S_SMP = 4'b0100, S_IDC = 4'b0010, S_BYP = 4'b0001;

    task automatic push(input string n, input bit w8, input logic t,
                        input logic [7:0] i, input logic [7:0] s, input logic [3:0] sl);
        exp_t e;
        e.name = n; e.w8 = w8; e.due = cyc + 1;
        e.tdo = t; e.instr = i; e.sr = s; e.sel = sl;
        q.push_back(e);
    endtask

    // one edge on the 4-bit instance; expected state is after that edge
    task automatic step_a(input string n, input logic r, input logic c, input logic s,
                          input logic u, input logic t, input logic [1:0] st,
                          input logic e_tdo, input logic [3:0] e_instr,
                          input logic [3:0] e_sr, input logic [3:0] e_sel);
        reset_a = r; cap_a = c; sh_a = s; up_a = u; tdi_a = t; st_a = st;
        push(n, 1'b0, e_tdo, {4'h0, e_instr}, {4'h0, e_sr}, e_sel);
        @(posedge clock); #1;
    endtask

    task automatic step_b(input string n, input logic r, input logic c, input logic s,
                          input logic u, input logic t, input logic [5:0] st,
                          input logic e_tdo, input logic [7:0] e_instr,
                          input logic [7:0] e_sr, input logic [3:0] e_sel);
        reset_b = r; cap_b = c; sh_b = s; up_b = u; tdi_b = t; st_b = st;
        push(n, 1'b1, e_tdo, e_instr, e_sr, e_sel);
        @(posedge clock); #1;
    endtask

    initial begin
        reset_a = 1; cap_a = 0; sh_a = 0; up_a = 0; tdi_a = 0; st_a = 2'b00;
        reset_b = 1; cap_b = 0; sh_b = 0; up_b = 0; tdi_b = 0; st_b = 6'b0;
        @(posedge clock); #1;

        //      name        r  c  s  u  tdi st     tdo instr    sr       sel
        step_a("reset",     1, 0, 0, 0, 0, 2'b10, 1, 4'b0010, 4'b0001, S_IDC);
        step_a("hold",      0, 0, 0, 0, 1, 2'b10, 1, 4'b0010, 4'b0001, S_IDC);
        step_a("capture",   0, 1, 0, 0, 0, 2'b10, 1, 4'b0010, 4'b1001, S_IDC);
        step_a("cap_sh1",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0010, 4'b0100, S_IDC);
        step_a("cap_sh2",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0010, 4'b0010, S_IDC);
        step_a("cap_sh3",   0, 0, 1, 0, 0, 2'b10, 1, 4'b0010, 4'b0001, S_IDC);
        step_a("cap_sh4",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0010, 4'b0000, S_IDC);
        step_a("byp_sh1",   0, 0, 1, 0, 1, 2'b10, 0, 4'b0010, 4'b1000, S_IDC);
        step_a("byp_sh2",   0, 0, 1, 0, 1, 2'b10, 0, 4'b0010, 4'b1100, S_IDC);
        step_a("byp_sh3",   0, 0, 1, 0, 1, 2'b10, 0, 4'b0010, 4'b1110, S_IDC);
        step_a("byp_sh4",   0, 0, 1, 0, 1, 2'b10, 1, 4'b0010, 4'b1111, S_IDC);
        step_a("byp_upd",   0, 0, 0, 1, 0, 2'b10, 1, 4'b1111, 4'b1111, S_BYP);
        step_a("unk_sh1",   0, 0, 1, 0, 0, 2'b10, 1, 4'b1111, 4'b0111, S_BYP);
        step_a("unk_sh2",   0, 0, 1, 0, 1, 2'b10, 1, 4'b1111, 4'b1011, S_BYP);
        step_a("unk_sh3",   0, 0, 1, 0, 1, 2'b10, 1, 4'b1111, 4'b1101, S_BYP);
        step_a("unk_sh4",   0, 0, 1, 0, 0, 2'b10, 0, 4'b1111, 4'b0110, S_BYP);
        step_a("unk_upd",   0, 0, 0, 1, 0, 2'b10, 0, 4'b0110, 4'b0110, S_BYP);
        step_a("smp_sh1",   0, 0, 1, 0, 1, 2'b10, 1, 4'b0110, 4'b1011, S_BYP);
        step_a("smp_sh2",   0, 0, 1, 0, 0, 2'b10, 1, 4'b0110, 4'b0101, S_BYP);
        step_a("smp_sh3",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0110, 4'b0010, S_BYP);
        step_a("smp_sh4",   0, 0, 1, 0, 0, 2'b10, 1, 4'b0110, 4'b0001, S_BYP);
        step_a("sh_upd",    0, 0, 1, 1, 1, 2'b10, 0, 4'b0001, 4'b1000, S_SMP);
        step_a("ext_sh1",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0001, 4'b0100, S_SMP);
        step_a("ext_sh2",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0001, 4'b0010, S_SMP);
        step_a("ext_sh3",   0, 0, 1, 0, 0, 2'b10, 1, 4'b0001, 4'b0001, S_SMP);
        step_a("ext_sh4",   0, 0, 1, 0, 0, 2'b10, 0, 4'b0001, 4'b0000, S_SMP);
        step_a("ext_upd",   0, 0, 0, 1, 0, 2'b10, 0, 4'b0000, 4'b0000, S_EXT);
        step_a("cap_vs_sh", 0, 1, 1, 0, 0, 2'b11, 1, 4'b0000, 4'b1101, S_EXT);
        step_a("cap_upd",   0, 1, 0, 1, 0, 2'b01, 1, 4'b1101, 4'b0101, S_BYP);
        step_a("mid_sh1",   0, 0, 1, 0, 1, 2'b01, 0, 4'b1101, 4'b1010, S_BYP);
        step_a("mid_sh2",   0, 0, 1, 0, 1, 2'b01, 1, 4'b1101, 4'b1101, S_BYP);
        step_a("mid_reset", 1, 1, 1, 1, 1, 2'b11, 1, 4'b0010, 4'b0001, S_IDC);
        step_a("idle",      0, 0, 0, 0, 0, 2'b00, 1, 4'b0010, 4'b0001, S_IDC);

        //      name         r  c  s  u  tdi st         tdo instr  sr     sel
        step_b("w8_reset",   1, 0, 0, 0, 0, 6'b101101, 1, 8'h02, 8'h01, S_IDC);
        step_b("w8_capture", 0, 1, 0, 0, 0, 6'b101101, 1, 8'h02, 8'hB5, S_IDC);
        step_b("w8_sh1",     0, 0, 1, 0, 0, 6'b101101, 0, 8'h02, 8'h5A, S_IDC);
        step_b("w8_sh2",     0, 0, 1, 0, 0, 6'b101101, 1, 8'h02, 8'h2D, S_IDC);
        step_b("w8_sh3",     0, 0, 1, 0, 0, 6'b101101, 0, 8'h02, 8'h16, S_IDC);
        step_b("w8_sh4",     0, 0, 1, 0, 0, 6'b101101, 1, 8'h02, 8'h0B, S_IDC);
        step_b("w8_sh5",     0, 0, 1, 0, 0, 6'b101101, 1, 8'h02, 8'h05, S_IDC);
        step_b("w8_sh6",     0, 0, 1, 0, 0, 6'b101101, 0, 8'h02, 8'h02, S_IDC);
        step_b("w8_sh7",     0, 0, 1, 0, 0, 6'b101101, 1, 8'h02, 8'h01, S_IDC);
        step_b("w8_sh8",     0, 0, 1, 0, 0, 6'b101101, 0, 8'h02, 8'h00, S_IDC);
        step_b("w8_upd",     0, 0, 0, 1, 0, 6'b101101, 0, 8'h00, 8'h00, S_EXT);
        step_b("w8_mid_sh1", 0, 0, 1, 0, 1, 6'b101101, 0, 8'h00, 8'h80, S_EXT);
        step_b("w8_mid_sh2", 0, 0, 1, 0, 1, 6'b101101, 0, 8'h00, 8'hC0, S_EXT);
        step_b("w8_mid_rst", 1, 0, 1, 0, 1, 6'b101101, 1, 8'h02, 8'h01, S_IDC);
        step_b("w8_idle",    0, 0, 0, 0, 0, 6'b000000, 1, 8'h02, 8'h01, S_IDC);

        begin : drain
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 10) begin
                @(posedge clock);
                budget++;
            end
            @(negedge clock); #1;
            if (q.size() > 0) begin
                tests++;
                failed++;
                $display("FAIL drain: %0d entries left unchecked, want 0", q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/jtag_ir_param.md
# jtag_ir_param

Parametrised JTAG instruction register. It is the next generation of the fixed 2-bit instruction register and sits between the TAP controller and the test data register mux. It captures the mandatory "...01" pattern with status bits, shifts IR_WIDTH bits LSB-first from tdi to tdo, and latches a new instruction on update. It decodes that instruction into one-hot select lines, and any unrecognised opcode maps to BYPASS. The design runs on a single clock, and every control input is a synchronous, one-cycle-qualified enable driven by the TAP controller.

## Interface
Parameters:
- IR_WIDTH, 4: instruction length in bits. Legal range is 3 to 16.
- OP_EXTEST, 4'b0000: EXTEST opcode, IR_WIDTH bits wide.
- OP_SAMPLE, 4'b0001: SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010: IDCODE opcode. This is also the instruction loaded at reset.
- BYPASS: fixed at all-ones and not a parameter. The other opcodes must be distinct and must not be all-ones.

Ports:
- clock, in, 1: the only clock. All state changes on its rising edge.
- reset, in, 1: synchronous, active-high.
- captureir, in, 1: load the capture pattern into the shift stage.
- shiftir, in, 1: shift the shift stage one bit toward tdo.
- updateir, in, 1: copy the shift stage into the instruction latch.
- tdi, in, 1: serial data in.
- capture_status, in, IR_WIDTH-2: design status, loaded above the fixed "01" on capture.
- tdo, out, 1: serial data out, equal to shift stage bit 0.
- instr, out, IR_WIDTH: the current latched instruction.
- sel_extest, sel_sample, sel_idcode, sel_bypass, out, 1 each: one-hot decode of instr.

## Operation
- State:
  - shift stage sr[IR_WIDTH-1:0]
  - instruction latch ir[IR_WIDTH-1:0]
- Reset (reset=1 at an edge):
  - sr loads {capture_status=0..., 2'b01}, that is, zeros above 2'b01.
  - ir loads OP_IDCODE.
  - Resulting outputs: tdo=1, instr=OP_IDCODE, sel_idcode=1, all other selects 0.
- Capture (captureir=1): sr becomes {capture_status, 2'b01}. ir is unchanged.
- Shift (shiftir=1):
  - sr becomes {tdi, sr[IR_WIDTH-1:1]}, so bit 0 leaves first.
  - After IR_WIDTH shifts, tdo has presented the captured bits in order bit0, bit1, and so on.
  - ir and the decode outputs do not change during shifting.
- Update (updateir=1): ir takes the value of sr as it stood before the edge.
- Decode (combinational from ir only):
  - ir == OP_EXTEST drives sel_extest.
  - ir == OP_SAMPLE drives sel_sample.
  - ir == OP_IDCODE drives sel_idcode.
  - Every other value, including all-ones, drives sel_bypass.
  - Exactly one select is high at all times.
- Simultaneous enables:
  - reset overrides everything.
  - For sr, captureir takes priority over shiftir.
  - updateir acts on ir independently, always using the pre-edge sr. With shiftir and updateir on the same edge, ir gets the old sr and sr shifts.
- Shift length: the shift stage does not count bits. Shifting more than IR_WIDTH times just keeps rotating in tdi. Only the last IR_WIDTH bits shifted are present at update.
- No enables asserted: all state holds.

## Timing
- tdo is combinational from sr[0]. It is valid in the cycle after each capture or shift edge.
- Update-to-decode latency is one edge. instr and the selects change right after the updateir edge and are glitch-free, since they decode registered ir.
- Capture-to-tdo latency is one edge. tdo=1 right after the capture edge.
- Reset mid-shift: sr and ir re-initialise on that edge, and the partially shifted data is lost.
- Reset takes effect only at a clock edge, never asynchronously.

## Test plan
- Reset: assert reset for 1 cycle, then release → instr=4'b0010, sel_idcode=1, tdo=1.
- Capture and shift-out: capture_status=2'b10, pulse captureir, then 4 shift cycles with tdi=0 → tdo sequence 1,0,0,1, and afterwards sr=0.
- Load BYPASS: shift in 1,1,1,1, then pulse updateir → instr=4'b1111 and sel_bypass=1. Before the update edge, instr stays at its old value through all shifts.
- Unknown opcode: shift in 4'b0110 (tdi order 0,1,1,0), then update → sel_bypass=1, the other selects 0, instr=4'b0110.
- Same-edge conflicts:
  - captureir and shiftir together → capture wins (sr={status,01}).
  - shiftir and updateir together with sr=4'b0001 → ir=4'b0001 (SAMPLE) and sr shifted.
- Reset mid-operation: after 2 shifts of a pattern, assert reset → instr=OP_IDCODE and sr=4'b0001. Repeat with IR_WIDTH=8 and OP_IDCODE=8'h02 → tdo presents 8 captured bits.
